// File: rtl/contador_mod.sv
// contador_mod -- parametrised modulo counter with prescaler, enable,
// synchronous clear/load, one-shot mode and terminal-count signalling.
// Supplies unit timing and symbol/element indexing for the Morse transmitter.
//
// Parameters:
//   WIDTH    count register width
//   MODULO   count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   PRESCALE CLK cycles per count step (1..65536)
//
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   en        count enable (freezes prescaler and count when low)
//   clr       synchronous clear of count, prescaler and done
//   load      synchronous load of load_val (clamped to MODULO-1)
//   load_val  value to load
//   dir       1 = up, 0 = down (only with CONTADOR_DOWN_EN)
//   oneshot   1 = halt at terminal value, 0 = wrap
//   salida    current count
//   tc        one-cycle terminal-count pulse
//   done      one-shot halted flag
//
// Build option: define CONTADOR_DOWN_EN to enable down counting via dir.
// Without it the counter is up-only and dir is ignored.
module contador_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             oneshot,
    output logic [WIDTH-1:0] salida,
    output logic             tc,
    output logic             done
);

    localparam int               PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] TOP       = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [PS_W-1:0]  PS_RELOAD = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE    = PS_W'(1);

    // Prescaler runs as a down-counter: reload value PRESCALE-1 corresponds to
    // phase 0, and reaching zero marks the step cycle.
    logic [PS_W-1:0]  ps_cnt;
    logic             at_term;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] load_clamped;

`ifdef CONTADOR_DOWN_EN
    always_comb begin
        at_term  = 1'b0;
        next_val = salida;
        if (dir) begin
            at_term  = (salida == TOP);
            next_val = at_term ? '0 : salida + ONE;
        end else begin
            at_term  = (salida == '0);
            next_val = at_term ? TOP : salida - ONE;
        end
    end
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign at_term    = (salida == TOP);
    assign next_val   = at_term ? '0 : salida + ONE;
`endif

    // Out-of-range loads saturate rather than wrap.
    assign load_clamped = (load_val > TOP) ? TOP : load_val;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            salida <= '0;
            ps_cnt <= PS_RELOAD;
            tc     <= 1'b0;
            done   <= 1'b0;
        end else if (load) begin
            salida <= load_clamped;
            ps_cnt <= PS_RELOAD;
            tc     <= 1'b0;
            done   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (en && !done) begin
                if (ps_cnt == '0) begin
                    ps_cnt <= PS_RELOAD;
                    if (at_term) begin
                        tc <= 1'b1;
                        // One-shot holds the terminal value instead of wrapping.
                        if (oneshot) begin
                            done <= 1'b1;
                        end else begin
                            salida <= next_val;
                        end
                    end else begin
                        salida <= next_val;
                    end
                end else begin
                    ps_cnt <= ps_cnt - PS_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_contador_mod.sv
module tb_contador_mod;

    logic       CLK = 1'b0;
    logic       RST, en, clr, load, dir, oneshot;
    logic [3:0] load_val;

    logic [3:0][3:0] sal;
    logic [3:0]      tcv;
    logic [3:0]      dnv;

    // inst 0: M=10 P=1, inst 1: M=16 P=3, inst 2: M=5 P=1, inst 3: M=6 P=1
    contador_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u0 (
        .CLK(CLK), .RST(RST), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .oneshot(oneshot), .salida(sal[0]), .tc(tcv[0]), .done(dnv[0]));
    contador_mod #(.WIDTH(4), .MODULO(16), .PRESCALE(3)) u1 (
        .CLK(CLK), .RST(RST), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .oneshot(oneshot), .salida(sal[1]), .tc(tcv[1]), .done(dnv[1]));
    contador_mod #(.WIDTH(4), .MODULO(5), .PRESCALE(1)) u2 (
        .CLK(CLK), .RST(RST), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .oneshot(oneshot), .salida(sal[2]), .tc(tcv[2]), .done(dnv[2]));
    contador_mod #(.WIDTH(4), .MODULO(6), .PRESCALE(1)) u3 (
        .CLK(CLK), .RST(RST), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .dir(dir), .oneshot(oneshot), .salida(sal[3]), .tc(tcv[3]), .done(dnv[3]));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         inst;
        logic [3:0] s;
        logic       t;
        logic       d;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: every negedge, pop the expectations stamped for this cycle.
    always @(negedge CLK) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc != cyc || sal[e.inst] !== e.s || tcv[e.inst] !== e.t || dnv[e.inst] !== e.d) begin
                n_bad++;
                $display("FAIL %s: cyc %0d inst %0d got salida=%0d tc=%0b done=%0b, want salida=%0d tc=%0b done=%0b",
                         e.nm, cyc, e.inst, sal[e.inst], tcv[e.inst], dnv[e.inst], e.s, e.t, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input int inst, input int s, input bit t, input bit d, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.inst = inst;
        e.s    = 4'(s);
        e.t    = t;
        e.d    = d;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_b1 [9] = '{0, 0, 1, 1, 1, 1, 1, 2, 2};
        int exp_b0 [9] = '{1, 2, 3, 4, 4, 4, 5, 6, 7};
`ifdef CONTADOR_DOWN_EN
        int dn_s [4] = '{1, 0, 5, 4};
        bit dn_t [4] = '{0, 0, 1, 0};
        int up_s [2] = '{5, 0};
        bit up_t [2] = '{0, 1};
`else
        int dn_s [4] = '{3, 4, 5, 0};
        bit dn_t [4] = '{0, 0, 0, 1};
        int up_s [2] = '{1, 2};
        bit up_t [2] = '{0, 0};
`endif

        RST = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
        dir = 1'b1; oneshot = 1'b0;

        // Reset and period
        tick(); tick();
        for (int i = 0; i < 4; i++) chk(i, 0, 0, 0, "reset");
        RST = 1'b0; en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk(0, k % 10, k == 10, 0, "mod10_seq");
            chk(1, k / 3, 0, 0, "ps3_seq");
        end

        // Prescale with enable dropped mid-phase
        RST = 1'b1; en = 1'b0; tick(); RST = 1'b0; en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk(1, exp_b1[k-1], 0, 0, "en_stretch");
            chk(0, exp_b0[k-1], 0, 0, "en_freeze");
            if (k == 4) en = 1'b0;
            if (k == 6) en = 1'b1;
        end

        // One-shot
        RST = 1'b1; en = 1'b0; oneshot = 1'b1; tick(); RST = 1'b0; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk(2, (k < 5) ? k : 4, k == 5, k >= 5, "oneshot");
        end
        clr = 1'b1; tick(); clr = 1'b0;
        chk(2, 0, 0, 0, "oneshot_clr");
        tick();
        chk(2, 1, 0, 0, "after_clr");
        oneshot = 1'b0;

        // Load priority and clamp
        RST = 1'b1; en = 1'b0; tick(); RST = 1'b0;
        load = 1'b1; load_val = 4'd12; tick();
        chk(0, 9, 0, 0, "clamp12");
        chk(1, 12, 0, 0, "load12_m16");
        load = 1'b0; en = 1'b1; tick();
        chk(0, 0, 1, 0, "wrap_after_load");
        load = 1'b1; clr = 1'b1; load_val = 4'd5; tick();
        chk(0, 0, 0, 0, "clr_over_load");
        clr = 1'b0; load_val = 4'd3; tick();
        chk(0, 3, 0, 0, "load3");
        chk(1, 3, 0, 0, "load3_m16");
        load = 1'b0;
        for (int k = 4; k <= 9; k++) begin
            tick();
            chk(0, k, 0, 0, "run_to_T");
            chk(1, 3 + (k - 3) / 3, 0, 0, "load_ps_phase");
        end
        load = 1'b1; load_val = 4'd2; tick();
        chk(0, 2, 0, 0, "load_on_tc");
        load = 1'b0; tick();
        chk(0, 3, 0, 0, "after_load");

        // Synchronous reset mid-run (inst 1 at salida=7, ps phase 1)
        RST = 1'b1; en = 1'b0; tick(); RST = 1'b0; en = 1'b1;
        for (int k = 1; k <= 22; k++) tick();
        chk(1, 7, 0, 0, "pre_rst");
        chk(0, 2, 0, 0, "pre_rst_m10");
        RST = 1'b1; tick(); RST = 1'b0;
        for (int i = 0; i < 4; i++) chk(i, 0, 0, 0, "mid_rst");
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk(1, (k == 3) ? 1 : 0, 0, 0, "post_rst");
        end

        // Direction
        RST = 1'b1; en = 1'b0; tick(); RST = 1'b0;
        dir = 1'b0; load = 1'b1; load_val = 4'd2; tick();
        chk(3, 2, 0, 0, "dir_load");
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk(3, dn_s[k], dn_t[k], 0, "dir_down");
        end
        dir = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk(3, up_s[k], up_t[k], 0, "dir_flip");
        end

        tick(); tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
